// File: rtl/dmd_seq_pkg.sv
// Shared types and defaults for the DMD pattern sequencer.
// Holds the FSM state encoding, the default word/flush counts and the hold-length helper.
package dmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRELOAD,
    ST_FLUSH,
    ST_STREAM,
    ST_EXPOSE,
    ST_NEXT
  } seq_state_t;

  localparam int WORDS_1080P_DEF  = 8100;
  localparam int WORDS_WUXGA_DEF  = 9000;
  localparam int FLUSH_CYCLES_DEF = 4;
  localparam int WCNT_W           = 16;
  localparam int TCNT_W           = 24;

  // Down-counter preload for an N-cycle hold; a zero request still holds one cycle.
  function automatic logic [TCNT_W-1:0] hold_len_m1(input logic [TCNT_W-1:0] n);
    return (n == '0) ? '0 : n - TCNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero rather than wrapping.
// The sequencer times both the FIFO flush and the exposure hold with one instance.
module seq_down_counter #(
  parameter int W = 24
) (
  input  logic         system_clk,
  input  logic         system_reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset)                r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pattern_sequencer.sv
// DMD pattern sequencer: flushes the read FIFOs, streams one pattern's word pairs,
// holds it for the exposure time and steps through the stored patterns.
module pattern_sequencer
  import dmd_seq_pkg::*;
#(
  parameter int ID_W         = 15,
  parameter int WORDS_1080P  = WORDS_1080P_DEF,
  parameter int WORDS_WUXGA  = WORDS_WUXGA_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic            system_clk,
  input  logic            system_reset,
  input  logic            start,
  input  logic            stop,
  input  logic            repeat_en,
  input  logic [ID_W-1:0] num_patterns,
  input  logic [23:0]     exposure_cycles,
  input  logic            dmd_1080p_connected,
  input  logic            mem_preload_done,
  input  logic            rd_ab_fifo_valid,
  input  logic            rd_cd_fifo_valid,
  output logic [ID_W-1:0] rd_pattern_id,
  output logic            mem_read_enable,
  output logic            mem_rd_fifo_reset,
  output logic            dmd_get_data,
  output logic            busy,
  output logic            pattern_done,
  output logic            seq_done,
  output logic            aborted
);

  localparam logic [TCNT_W-1:0] FLUSH_M1 = TCNT_W'(FLUSH_CYCLES - 1);

  seq_state_t        r_state;
  logic [ID_W-1:0]   r_id;
  logic [WCNT_W-1:0] r_words;
  logic [WCNT_W-1:0] r_target;
  logic              r_rd_en, r_fifo_rst, r_busy;
  logic              r_pattern_done, r_seq_done, r_aborted;

  logic              w_get, w_last_word, w_more;
  logic [WCNT_W-1:0] w_target;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [TCNT_W-1:0] w_cnt_val;

  assign w_get       = (r_state == ST_STREAM) && rd_ab_fifo_valid && rd_cd_fifo_valid;
  assign w_last_word = w_get && ((r_words + WCNT_W'(1)) == r_target);
  // Compare against the live num_patterns, one bit wider so 0 never underflows.
  assign w_more      = ({1'b0, r_id} + (ID_W+1)'(1)) < {1'b0, num_patterns};
  assign w_target    = dmd_1080p_connected ? WCNT_W'(WORDS_1080P) : WCNT_W'(WORDS_WUXGA);

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = FLUSH_M1;
    if (!stop) begin
      unique case (r_state)
        ST_WAIT_PRELOAD: w_cnt_load = mem_preload_done;
        ST_NEXT:         w_cnt_load = w_more || repeat_en;
        ST_STREAM: begin
          w_cnt_load = w_last_word;
          w_cnt_val  = hold_len_m1(exposure_cycles);
        end
        ST_FLUSH, ST_EXPOSE: w_cnt_dec = 1'b1;
        default: ;
      endcase
    end
  end

  seq_down_counter #(.W(TCNT_W)) u_timer (
    .system_clk   (system_clk),
    .system_reset (system_reset),
    .i_load       (w_cnt_load),
    .i_dec        (w_cnt_dec),
    .i_load_val   (w_cnt_val),
    .o_zero       (w_cnt_zero)
  );

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      r_state        <= ST_IDLE;
      r_id           <= '0;
      r_words        <= '0;
      r_target       <= '0;
      r_rd_en        <= 1'b0;
      r_fifo_rst     <= 1'b0;
      r_busy         <= 1'b0;
      r_pattern_done <= 1'b0;
      r_seq_done     <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      r_pattern_done <= 1'b0;
      r_seq_done     <= 1'b0;
      r_aborted      <= 1'b0;
      if (stop && r_state != ST_IDLE) begin
        r_state    <= ST_IDLE;
        r_rd_en    <= 1'b0;
        r_fifo_rst <= 1'b0;
        r_busy     <= 1'b0;
        r_aborted  <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: if (start && !stop && num_patterns != '0) begin
            r_id    <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT_PRELOAD;
          end
          ST_WAIT_PRELOAD: if (mem_preload_done) begin
            r_fifo_rst <= 1'b1;
            r_state    <= ST_FLUSH;
          end
          ST_FLUSH: if (w_cnt_zero) begin
            r_fifo_rst <= 1'b0;
            r_rd_en    <= 1'b1;
            r_words    <= '0;
            r_target   <= w_target;
            r_state    <= ST_STREAM;
          end
          ST_STREAM: if (w_get) begin
            r_words <= r_words + WCNT_W'(1);
            if (w_last_word) begin
              r_rd_en <= 1'b0;
              r_state <= ST_EXPOSE;
            end
          end
          ST_EXPOSE: if (w_cnt_zero) begin
            r_pattern_done <= 1'b1;
            r_state        <= ST_NEXT;
          end
          ST_NEXT: begin
            if (w_more || repeat_en) begin
              r_id       <= w_more ? r_id + ID_W'(1) : '0;
              r_fifo_rst <= 1'b1;
              r_state    <= ST_FLUSH;
            end else begin
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_pattern_id     = r_id;
  assign mem_read_enable   = r_rd_en;
  assign mem_rd_fifo_reset = r_fifo_rst;
  assign dmd_get_data      = w_get;
  assign busy              = r_busy;
  assign pattern_done      = r_pattern_done;
  assign seq_done          = r_seq_done;
  assign aborted           = r_aborted;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus randomized runs, checked
// against per-pattern expectations (ids, pops, flush and exposure lengths).
module tb_pattern_sequencer;

  localparam int ID_W = 4;
  localparam int W1   = 8;
  localparam int W2   = 12;
  localparam int FL   = 4;

  logic system_clk = 1'b0;
  logic system_reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, repeat_en = 1'b0;
  logic [ID_W-1:0] num_patterns = '0;
  logic [23:0] exposure_cycles = '0;
  logic dmd_1080p_connected = 1'b1, mem_preload_done = 1'b1;
  logic rd_ab_fifo_valid = 1'b1, rd_cd_fifo_valid = 1'b1;
  logic [ID_W-1:0] rd_pattern_id;
  logic mem_read_enable, mem_rd_fifo_reset, dmd_get_data, busy;
  logic pattern_done, seq_done, aborted;

  always #5 system_clk = ~system_clk;

  pattern_sequencer #(.ID_W(ID_W), .WORDS_1080P(W1), .WORDS_WUXGA(W2), .FLUSH_CYCLES(FL)) dut (
    .system_clk(system_clk), .system_reset(system_reset), .start(start), .stop(stop),
    .repeat_en(repeat_en), .num_patterns(num_patterns), .exposure_cycles(exposure_cycles),
    .dmd_1080p_connected(dmd_1080p_connected), .mem_preload_done(mem_preload_done),
    .rd_ab_fifo_valid(rd_ab_fifo_valid), .rd_cd_fifo_valid(rd_cd_fifo_valid),
    .rd_pattern_id(rd_pattern_id), .mem_read_enable(mem_read_enable),
    .mem_rd_fifo_reset(mem_rd_fifo_reset), .dmd_get_data(dmd_get_data), .busy(busy),
    .pattern_done(pattern_done), .seq_done(seq_done), .aborted(aborted)
  );

  int total = 0, bad = 0;
  int vmode = 0;
  int id_q[$], pops_q[$], exp_q[$], flush_q[$], slen_q[$];
  int pops, slen, gap, flen, stream_cnt, pd_cnt, sd_cnt, ab_cnt, frst_total, viol, cur_id;
  bit prev_rd, prev_fr, in_gap;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    id_q.delete(); pops_q.delete(); exp_q.delete(); flush_q.delete(); slen_q.delete();
    pops = 0; slen = 0; gap = 0; flen = 0; stream_cnt = 0; pd_cnt = 0; sd_cnt = 0;
    ab_cnt = 0; frst_total = 0; viol = 0; cur_id = 0;
    prev_rd = 0; prev_fr = 0; in_gap = 0;
  endtask

  // Observes one cycle of outputs and folds it into per-pattern records.
  task automatic monitor();
    if (dmd_get_data) begin
      pops++;
      if (!(rd_ab_fifo_valid && rd_cd_fifo_valid && mem_read_enable)) viol++;
    end
    if (mem_read_enable && mem_rd_fifo_reset) viol++;
    if (busy && rd_pattern_id >= num_patterns) viol++;
    if (mem_read_enable) begin
      if (!prev_rd) begin stream_cnt++; slen = 0; pops = dmd_get_data ? 1 : 0; cur_id = int'(rd_pattern_id); end
      else if (int'(rd_pattern_id) != cur_id) viol++;
      slen++;
    end else if (prev_rd) begin
      id_q.push_back(cur_id); pops_q.push_back(pops); slen_q.push_back(slen);
      pops = 0; in_gap = 1; gap = 0;
    end
    if (pattern_done) begin
      pd_cnt++;
      if (in_gap) exp_q.push_back(gap);
      in_gap = 0;
    end else if (in_gap) gap++;
    if (mem_rd_fifo_reset) begin flen++; frst_total++; end
    else if (prev_fr) begin flush_q.push_back(flen); flen = 0; end
    if (seq_done) sd_cnt++;
    if (aborted) ab_cnt++;
    prev_rd = mem_read_enable; prev_fr = mem_rd_fifo_reset;
  endtask

  task automatic step();
    @(negedge system_clk); monitor();
    @(posedge system_clk); #1;
    case (vmode)
      0: begin rd_ab_fifo_valid = 1'b1; rd_cd_fifo_valid = 1'b1; end
      1: begin rd_ab_fifo_valid = 1'b1; rd_cd_fifo_valid = ~rd_cd_fifo_valid; end
      default: begin
        rd_ab_fifo_valid = ($urandom_range(3) != 0);
        rd_cd_fifo_valid = ($urandom_range(3) != 0);
      end
    endcase
  endtask

  task automatic wait_stream(input string tag, input int n);
    int k = 0;
    while (stream_cnt < n && k < 2000) begin step(); k++; end
    chk({tag, "_stream_reached"}, stream_cnt >= n, 1);
  endtask

  task automatic run_to_done(input string tag, input int busy_start_at);
    int k = 0;
    while (sd_cnt == 0 && ab_cnt == 0 && k < 3000) begin
      start = (k == busy_start_at);
      step(); k++;
    end
    start = 1'b0;
    step();
    chk({tag, "_done_in_budget"}, sd_cnt, 1);
  endtask

  task automatic run_seq(input string tag, input int num, input int exp, input int sel);
    clear_mon();
    num_patterns = ID_W'(num); exposure_cycles = 24'(exp); dmd_1080p_connected = sel[0];
    start = 1'b1; step(); start = 1'b0;
    run_to_done(tag, 10);
  endtask

  task automatic check_run(input string tag, input int num, input int exp, input int sel);
    int tgt = (sel != 0) ? W1 : W2;
    int hold = (exp == 0) ? 1 : exp;
    chk({tag, "_num_streams"}, id_q.size(), num);
    chk({tag, "_num_flushes"}, flush_q.size(), num);
    chk({tag, "_num_exposes"}, exp_q.size(), num);
    for (int i = 0; i < num; i++) begin
      if (i < id_q.size()) begin
        chk($sformatf("%s_id%0d", tag, i), id_q[i], i);
        chk($sformatf("%s_pops%0d", tag, i), pops_q[i], tgt);
      end
      if (i < flush_q.size()) chk($sformatf("%s_flush%0d", tag, i), flush_q[i], FL);
      if (i < exp_q.size()) chk($sformatf("%s_expose%0d", tag, i), exp_q[i], hold);
    end
    chk({tag, "_pattern_done"}, pd_cnt, num);
    chk({tag, "_aborted"}, ab_cnt, 0);
    chk({tag, "_invariants"}, viol, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    clear_mon();
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_id", rd_pattern_id, 0);
    chk("rst_rd_en", mem_read_enable, 0);
    chk("rst_fifo_rst", mem_rd_fifo_reset, 0);
    chk("rst_get", dmd_get_data, 0);
    chk("rst_pulses", {pattern_done, seq_done, aborted}, 0);
    system_reset = 1'b0;
    step();

    // Two patterns, no repeat.
    run_seq("A", 2, 10, 1);
    check_run("A", 2, 10, 1);

    // Repeat mode, abort during third stream.
    clear_mon();
    repeat_en = 1'b1; num_patterns = ID_W'(2); exposure_cycles = 24'd10;
    start = 1'b1; step(); start = 1'b0;
    wait_stream("B", 3);
    step(); step();
    chk("B_in_stream", mem_read_enable, 1);
    chk("B_streams_before_stop", id_q.size(), 2);
    if (id_q.size() == 2) begin
      chk("B_id0", id_q[0], 0);
      chk("B_id1", id_q[1], 1);
    end
    chk("B_third_id", cur_id, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("B_aborted_pulse", aborted, 1);
    chk("B_rd_en_off", mem_read_enable, 0);
    chk("B_get_off", dmd_get_data, 0);
    chk("B_fifo_rst_off", mem_rd_fifo_reset, 0);
    chk("B_busy_off", busy, 0);
    step(); step(); step();
    chk("B_abort_count", ab_cnt, 1);
    chk("B_no_seq_done", sd_cnt, 0);
    chk("B_pattern_done", pd_cnt, 2);
    repeat_en = 1'b0;

    // Preload gating.
    clear_mon();
    mem_preload_done = 1'b0; num_patterns = ID_W'(1); exposure_cycles = 24'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 50; i++) step();
    chk("C_busy_waiting", busy, 1);
    chk("C_no_flush", frst_total, 0);
    chk("C_no_stream", stream_cnt, 0);
    chk("C_fifo_rst_before", mem_rd_fifo_reset, 0);
    mem_preload_done = 1'b1;
    step();
    chk("C_flush_starts", mem_rd_fifo_reset, 1);
    run_to_done("C", -1);
    check_run("C", 1, 3, 1);

    // Half-rate CD valid.
    vmode = 1;
    run_seq("D", 1, 2, 1);
    check_run("D", 1, 2, 1);
    if (slen_q.size() > 0) chk("D_stream_len", (slen_q[0] >= 15 && slen_q[0] <= 16), 1);
    vmode = 0;

    // Zero exposure on WUXGA.
    run_seq("Z", 1, 0, 0);
    check_run("Z", 1, 0, 0);

    // Randomized runs with valid dropouts.
    vmode = 2;
    for (int it = 0; it < 6; it++) begin
      int n = int'($urandom_range(3, 1));
      int e = int'($urandom_range(6, 0));
      int s = int'($urandom_range(1, 0));
      run_seq($sformatf("R%0d", it), n, e, s);
      check_run($sformatf("R%0d", it), n, e, s);
    end
    vmode = 0;

    // Shrinking num_patterns mid-sequence ends after the current pattern.
    clear_mon();
    num_patterns = ID_W'(3); exposure_cycles = 24'd2;
    start = 1'b1; step(); start = 1'b0;
    wait_stream("L", 1);
    num_patterns = ID_W'(1);
    run_to_done("L", -1);
    chk("L_streams", id_q.size(), 1);
    chk("L_pattern_done", pd_cnt, 1);

    // Ignored starts: zero patterns, and start together with stop.
    clear_mon();
    num_patterns = '0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("N0_busy", busy, 0);
    chk("N0_no_flush", frst_total, 0);
    num_patterns = ID_W'(1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    step(); step();
    chk("SS_busy", busy, 0);
    chk("SS_no_abort", ab_cnt, 0);

    // Asynchronous reset mid-stream of the second pattern.
    clear_mon();
    num_patterns = ID_W'(2); exposure_cycles = 24'd5;
    start = 1'b1; step(); start = 1'b0;
    wait_stream("X", 2);
    step(); step();
    chk("X_pre_rd_en", mem_read_enable, 1);
    chk("X_pre_id", rd_pattern_id, 1);
    #2 system_reset = 1'b1;
    #1;
    chk("X_rd_en", mem_read_enable, 0);
    chk("X_get", dmd_get_data, 0);
    chk("X_fifo_rst", mem_rd_fifo_reset, 0);
    chk("X_busy", busy, 0);
    chk("X_id", rd_pattern_id, 0);
    chk("X_pulses", {pattern_done, seq_done, aborted}, 0);
    step(); step();
    system_reset = 1'b0;
    step(); step(); step();
    chk("X_no_abort", ab_cnt, 0);
    chk("X_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have the parameter ID_W, default 15, giving the pattern-id width.
REQ-002 The block SHALL have the parameter WORDS_1080P, default 8100, giving the 256-bit word pairs per pattern for a 1080p DMD.
REQ-003 The block SHALL have the parameter WORDS_WUXGA, default 9000, giving the word pairs per pattern for a WUXGA DMD.
REQ-004 The block SHALL have the parameter FLUSH_CYCLES, default 4, giving the read-FIFO reset pulse length in cycles.
REQ-005 Ports, clock and reset first:
  - system_clk  in  1  sole clock; one clock only.
  - system_reset  in  1  asynchronous, active-high reset.
  - start  in  1  single-cycle sequence start request.
  - stop  in  1  single-cycle abort request.
  - repeat_en  in  1  wrap to pattern 0 after the last pattern instead of finishing.
  - num_patterns  in  ID_W  number of stored patterns.
  - exposure_cycles  in  24  display hold time per pattern, in system_clk cycles.
  - dmd_1080p_connected  in  1  selects WORDS_1080P (1) or WORDS_WUXGA (0).
  - mem_preload_done  in  1  DDR2 preload complete.
  - rd_ab_fifo_valid, rd_cd_fifo_valid  in  1 each  read-FIFO data available.
  - rd_pattern_id  out  ID_W  pattern currently fetched.
  - mem_read_enable  out  1  memory read request.
  - mem_rd_fifo_reset  out  1  read-FIFO flush.
  - dmd_get_data  out  1  pop both read FIFOs.
  - busy  out  1  high in any state other than IDLE.
  - pattern_done  out  1  one-cycle pulse at the end of each exposure.
  - seq_done  out  1  one-cycle pulse on normal completion.
  - aborted  out  1  one-cycle pulse on stop.

Function
REQ-006 States SHALL be IDLE, WAIT_PRELOAD, FLUSH, STREAM, EXPOSE and NEXT.
REQ-007 In IDLE, start with num_patterns>0 SHALL set rd_pattern_id to 0 and go to WAIT_PRELOAD.
REQ-008 In IDLE, start with num_patterns==0 SHALL be ignored, and the block SHALL remain in IDLE.
REQ-009 WAIT_PRELOAD SHALL go to FLUSH on the first cycle mem_preload_done=1.
REQ-010 FLUSH SHALL assert mem_rd_fifo_reset for exactly FLUSH_CYCLES cycles, with mem_read_enable=0, then go to STREAM.
REQ-011 STREAM SHALL hold mem_read_enable=1 and rd_pattern_id stable.
REQ-012 In STREAM, dmd_get_data SHALL equal rd_ab_fifo_valid AND rd_cd_fifo_valid (combinational), and it SHALL be 0 in every other state.
REQ-013 Each cycle with dmd_get_data=1 SHALL increment a 16-bit word counter, which is cleared on entry to STREAM.
REQ-014 The word that brings the counter to the target (WORDS_1080P or WORDS_WUXGA, sampled on STREAM entry) SHALL move the FSM to EXPOSE on the next cycle, with mem_read_enable=0 from that cycle.
REQ-015 EXPOSE SHALL count exposure_cycles (sampled on entry) and then pulse pattern_done while going to NEXT.
REQ-016 exposure_cycles=0 SHALL be treated as 1.
REQ-017 In NEXT, rd_pattern_id<num_patterns-1 SHALL increment rd_pattern_id and go to FLUSH.
REQ-018 In NEXT, on the last pattern with repeat_en=1, the block SHALL load rd_pattern_id=0 and go to FLUSH.
REQ-019 In NEXT, on the last pattern with repeat_en=0, the block SHALL pulse seq_done and go to IDLE.
REQ-020 stop in any non-IDLE state SHALL force IDLE on the next cycle and pulse aborted.
REQ-021 On stop, mem_read_enable, dmd_get_data and mem_rd_fifo_reset SHALL deassert in that same next cycle.
REQ-022 stop and start asserted together SHALL give priority to stop.
REQ-023 start while busy SHALL be ignored.
REQ-024 rd_pattern_id SHALL never reach or exceed num_patterns.
REQ-025 If num_patterns is changed mid-sequence, the wrap comparison SHALL use the live value.
REQ-026 A dropout of FIFO valid during STREAM SHALL stall the counter with no timeout.

Reset
REQ-027 system_reset=1 SHALL asynchronously force state IDLE and clear all outputs and counters, including rd_pattern_id=0.
REQ-028 Reset asserted mid-operation SHALL abandon the transfer without an aborted pulse.

Structure
REQ-029 The state encoding and the WORDS_* and FLUSH_CYCLES defaults SHALL live in a shared package, dmd_seq_pkg.
REQ-030 A single sub-module, seq_down_counter (a loadable down-counter with a zero flag), SHALL be used for both the flush and exposure timing.

Verification
REQ-031 Scenario: WORDS_1080P=8, FLUSH_CYCLES=4, num_patterns=2, exposure=10, repeat_en=0, preload_done high, both valid high -> ids 0 then 1 are fetched, 8 pops each, 2 pattern_done pulses, then seq_done, and busy low afterwards.
REQ-032 Scenario: same setup with repeat_en=1 -> the id sequence is 0,1,0,1,...; stop during the third STREAM -> aborted pulse, with read_enable and get_data low the next cycle.
REQ-033 Scenario: start while mem_preload_done=0 for 50 cycles -> the block holds WAIT_PRELOAD with mem_rd_fifo_reset=0, and FLUSH begins the cycle after preload_done rises.
REQ-034 Scenario: rd_cd_fifo_valid toggles every other cycle -> exactly 8 pops occur, only on cycles where both valids are high, and STREAM lasts about 16 cycles.
REQ-035 Scenario: num_patterns=0 with start -> busy stays 0; exposure_cycles=0 -> EXPOSE lasts 1 cycle.
REQ-036 Scenario: system_reset asserted mid-STREAM -> all outputs are 0 immediately and asynchronously, and no aborted pulse occurs.
